// File: rtl/logicnet_input_quantizer_if.sv
// Stream bundle between the raw-feature source, the input quantizer and layer0.
// The master side drives samples and consumes vectors; the slave side is the quantizer.
interface logicnet_input_quantizer_if #(
  parameter int IN_WIDTH     = 8,
  parameter int NUM_FEATURES = 8
);
  localparam int OUT_W = NUM_FEATURES * 2;

  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic                frame_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, frame_err
  );
endinterface

// File: rtl/logicnet_input_quantizer.sv
// Input quantizer for the LogicNet classifier front end.
// Each accepted sample is thresholded to a 2-bit code and packed into the next
// accumulator slot; a frame end (in_last) or a full accumulator publishes the
// vector one cycle later. frame_err flags frames whose length differs from
// NUM_FEATURES. in_ready is combinational so a consumed vector frees the stage
// in the same cycle.
module logicnet_input_quantizer #(
  parameter int IN_WIDTH     = 8,
  parameter int NUM_FEATURES = 8,
  parameter int CODE_BITS    = 2,
  parameter int THR0         = 64,
  parameter int THR1         = 128,
  parameter int THR2         = 192
) (
  input logic                        clk,
  input logic                        rst,
  logicnet_input_quantizer_if.slave  bus
);
  localparam int OUT_W = NUM_FEATURES * CODE_BITS;
  localparam int CNT_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_FEATURES - 1);

  // Three unsigned threshold compares summed into a thermometer-style code.
  function automatic logic [1:0] quantize(input logic [IN_WIDTH-1:0] d);
    logic [1:0] ge0;
    logic [1:0] ge1;
    logic [1:0] ge2;
    ge0 = {1'b0, (d >= IN_WIDTH'(THR0))};
    ge1 = {1'b0, (d >= IN_WIDTH'(THR1))};
    ge2 = {1'b0, (d >= IN_WIDTH'(THR2))};
    return ge0 + ge1 + ge2;
  endfunction

  logic [CNT_W-1:0] count_q,     count_d;
  logic [OUT_W-1:0] acc_q,       acc_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic             frame_err_q, frame_err_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             last_slot_s;
  logic             complete_s;
  logic             misalign_s;
  logic [OUT_W-1:0] acc_ins_s;

  // The stage is free whenever no vector is pending or layer0 takes it now.
  assign in_ready_s = ~out_valid_q | bus.out_ready;

  // Accept/completion decode and next-state for counter, accumulator and outputs.
  always_comb begin
    last_slot_s = (count_q == LAST_SLOT);
    accept_s    = bus.in_valid & in_ready_s;
    complete_s  = accept_s & (bus.in_last | last_slot_s);
    // Misaligned when frame end and vector end disagree on this sample.
    misalign_s  = accept_s & (bus.in_last ^ last_slot_s);

    acc_ins_s = acc_q;
    if (accept_s) begin
      acc_ins_s[count_q*CODE_BITS +: CODE_BITS] = quantize(bus.in_data);
    end else begin
      acc_ins_s = acc_q;
    end

    count_d     = count_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_data_d  = out_data_q;
    frame_err_d = 1'b0;

    if (complete_s) begin
      count_d     = {CNT_W{1'b0}};
      acc_d       = {OUT_W{1'b0}};
      out_valid_d = 1'b1;
      out_data_d  = acc_ins_s;
      frame_err_d = misalign_s;
    end else if (accept_s) begin
      count_d = count_q + CNT_W'(1);
      acc_d   = acc_ins_s;
    end else begin
      count_d = count_q;
      acc_d   = acc_q;
    end
  end

  // State and registered outputs; reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= {CNT_W{1'b0}};
      acc_q       <= {OUT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      frame_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Self-checking bench for logicnet_input_quantizer: directed scenarios followed
// by random traffic, compared against a frame-level reference model.
module tb_logicnet_input_quantizer;
  localparam int NF = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logicnet_input_quantizer_if #(.IN_WIDTH(8), .NUM_FEATURES(NF)) bus ();

  logicnet_input_quantizer #(
    .IN_WIDTH(8), .NUM_FEATURES(NF), .CODE_BITS(2),
    .THR0(64), .THR1(128), .THR2(192)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: codes of the frame in progress and expected outputs.
  logic [1:0]  frame_q[$];
  logic        exp_valid;
  logic [15:0] exp_data;
  logic        exp_err;
  logic        last_acc;
  int          thr[3] = '{64, 128, 192};

  function automatic logic [1:0] ref_code(input logic [7:0] d);
    int n;
    n = 0;
    foreach (thr[i]) if (int'(d) >= thr[i]) n++;
    return 2'(n);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic ordy);
    logic        m_ready;
    logic [15:0] vec;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    #1;
    m_ready = !exp_valid || ordy;
    check("in_ready", 32'(bus.in_ready), 32'(m_ready));
    last_acc = v && m_ready;
    exp_err  = 1'b0;
    if (exp_valid && ordy) exp_valid = 1'b0;
    if (last_acc) begin
      frame_q.push_back(ref_code(d));
      if (l || frame_q.size() == NF) begin
        vec = 16'h0000;
        foreach (frame_q[k]) vec = vec | (16'(frame_q[k]) << (2 * k));
        exp_err   = l ? (frame_q.size() < NF) : 1'b1;
        exp_valid = 1'b1;
        exp_data  = vec;
        frame_q.delete();
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check("out_data",  32'(bus.out_data),  32'(exp_data));
    check("frame_err", 32'(bus.frame_err), 32'(exp_err));
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic ordy);
    int n;
    n = 0;
    do begin
      cycle(1'b1, d, l, ordy);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) check("send_timeout", 32'(last_acc), 32'd1);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame_q.delete();
    exp_valid = 1'b0;
    exp_data  = 16'h0000;
    exp_err   = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
  endtask

  task automatic frame2(input logic ordy);
    logic [7:0] s[8] = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};
    for (int i = 0; i < 8; i++) send(s[i], (i == 7), ordy);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    last_acc = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    #2;

    // 1: reset state
    do_reset();

    // 2: one sample per threshold band, aligned frame
    frame2(1'b1);
    check("s2_valid", 32'(bus.out_valid), 32'd1);
    check("s2_data",  32'(bus.out_data),  32'h0000FA50);
    check("s2_err",   32'(bus.frame_err), 32'd0);

    // 3: same frame with layer0 stalled, then release
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    frame2(1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'd255, 1'b1, 1'b0);
      check("s3_hold_data",  32'(bus.out_data), 32'h0000FA50);
      check("s3_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    frame2(1'b1);
    check("s3_next_data", 32'(bus.out_data), 32'h0000FA50);

    // 4: short frame, zero padded
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    send(8'd255, 1'b0, 1'b1);
    send(8'd255, 1'b0, 1'b1);
    send(8'd255, 1'b1, 1'b1);
    check("s4_data", 32'(bus.out_data),  32'h0000003F);
    check("s4_err",  32'(bus.frame_err), 32'd1);
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    check("s4_err_pulse", 32'(bus.frame_err), 32'd0);

    // 5: long frame; the ninth sample starts a fresh vector
    for (int i = 0; i < 8; i++) send(8'd200, 1'b0, 1'b1);
    check("s5_data", 32'(bus.out_data),  32'h0000FFFF);
    check("s5_err",  32'(bus.frame_err), 32'd1);
    send(8'd255, 1'b1, 1'b1);
    check("s5_slot0", 32'(bus.out_data), 32'h00000003);

    // 6: reset mid-vector leaves no residue
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(8'd255, 1'b0, 1'b1);
    do_reset();
    frame2(1'b1);
    check("s6_data", 32'(bus.out_data), 32'h0000FA50);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
